// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pkg
// Description : Shared widths, constants, flag indices and FSM encoding for
//               the iterative single-precision multiplier sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_mul_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_norm_round
// Description : Combinational normalise, round-half-up and exception packing
//               of a 48-bit mantissa product (flush-to-zero, no denormals).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_norm_round
    import fp_mul_pkg::*;
(
    input  logic [PROD_W-1:0] prod,
    input  logic [9:0]        exp,
    input  logic              sign,
    output logic [31:0]       res,
    output logic [3:0]        flags
);

    logic              w_top;
    logic [FRAC_W-1:0] w_frac_pre;
    logic              w_guard;
    logic              w_sticky;
    logic [MANT_W:0]   w_rnd;
    logic [FRAC_W-1:0] w_frac;
    logic [9:0]        w_exp;

    always_comb begin
        w_top      = prod[PROD_W-1];
        w_frac_pre = w_top ? prod[46:24] : prod[45:23];
        w_guard    = w_top ? prod[23]    : prod[22];
        // every bit below the kept fraction, guard included, is discarded
        w_sticky   = w_top ? (|prod[23:0]) : (|prod[22:0]);
        w_rnd      = {2'b01, w_frac_pre} + {{MANT_W{1'b0}}, w_guard};
        w_frac     = w_rnd[MANT_W] ? w_rnd[MANT_W-1:1] : w_rnd[FRAC_W-1:0];
        w_exp      = exp + 10'(w_top) + 10'(w_rnd[MANT_W]);

        res                = {sign, w_exp[EXP_W-1:0], w_frac};
        flags              = '0;
        flags[FLG_INEXACT] = w_sticky;
        if ($signed(w_exp) >= 10'sd255) begin
            res                 = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags[FLG_OVERFLOW] = 1'b1;
        end else if ($signed(w_exp) <= 10'sd0) begin
            res                  = {sign, {(EXP_W + FRAC_W){1'b0}}};
            flags[FLG_UNDERFLOW] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_seq_ctrl
// Description : Handshake, FSM and shift-add datapath of an iterative IEEE-754
//               single-precision multiplier; result held until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_seq_ctrl
    import fp_mul_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [3:0]  out_flags
);

    localparam int c_MULT_CYC = MANT_W / RADIX_BITS;
    localparam int c_CNT_W    = (c_MULT_CYC > 1) ? $clog2(c_MULT_CYC + 1) : 1;

    state_t              r_state, w_state_nxt;
    logic                r_sign;
    logic [MANT_W-1:0]   r_ma, r_mb;
    logic [9:0]          r_exp;
    logic [PROD_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_res;
    logic [3:0]          r_flags;

    logic                w_accept, w_last, w_special;
    logic                w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [31:0]         w_spec_res;
    logic [3:0]          w_spec_flags;
    logic [5:0]          w_shamt;
    logic [PROD_W-1:0]   w_pp;
    logic [31:0]         w_nr_res;
    logic [3:0]          w_nr_flags;

    // Operand classification; exp field 0 (zero or denormal) counts as zero.
    always_comb begin
        w_a_nan   = (in_a[30:23] == 8'hFF) && (in_a[22:0] != '0);
        w_b_nan   = (in_b[30:23] == 8'hFF) && (in_b[22:0] != '0);
        w_a_inf   = (in_a[30:23] == 8'hFF) && (in_a[22:0] == '0);
        w_b_inf   = (in_b[30:23] == 8'hFF) && (in_b[22:0] == '0);
        w_a_zero  = (in_a[30:23] == 8'h00);
        w_b_zero  = (in_b[30:23] == 8'h00);
        w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

        w_spec_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_res                = QNAN;
            w_spec_flags[FLG_INVALID] = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_res = {in_a[31] ^ in_b[31], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            w_spec_res = {in_a[31] ^ in_b[31], {(EXP_W + FRAC_W){1'b0}}};
        end
    end

    assign w_accept = (r_state == ST_IDLE) && in_valid && !abort;
    assign w_last   = (r_cnt == c_CNT_W'(c_MULT_CYC - 1));
    assign w_shamt  = 6'(r_cnt) * 6'(RADIX_BITS);
    assign w_pp     = (PROD_W'(r_ma) * PROD_W'(r_mb[RADIX_BITS-1:0])) << w_shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_special ? ST_DONE : ST_MULT;
                end
            end
            ST_MULT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_state_nxt = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign  <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_exp   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign <= in_a[31] ^ in_b[31];
                        r_ma   <= {1'b1, in_a[22:0]};
                        r_mb   <= {1'b1, in_b[22:0]};
                        r_exp  <= 10'(in_a[30:23]) + 10'(in_b[30:23]) - 10'(BIAS);
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        if (w_special) begin
                            r_res   <= w_spec_res;
                            r_flags <= w_spec_flags;
                        end
                    end
                end
                ST_MULT: begin
                    r_acc <= r_acc + w_pp;
                    r_mb  <= r_mb >> RADIX_BITS;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                ST_ROUND: begin
                    if (!abort) begin
                        r_res   <= w_nr_res;
                        r_flags <= w_nr_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    fp_mul_norm_round u_norm_round (
        .prod  (r_acc),
        .exp   (r_exp),
        .sign  (r_sign),
        .res   (w_nr_res),
        .flags (w_nr_flags)
    );

    assign out_res   = r_res;
    assign out_flags = r_flags;

endmodule
`default_nettype wire
